// File: rtl/riscv_multicycle_ctrl_if.sv
// Control-to-datapath bundle of the multi-cycle RV32 core: memory handshake,
// datapath steering, trap flag and the retired-instruction count.
interface riscv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, instret
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 core (R-type, lw, sw, beq).
// Moore decode from state; only the FETCH/BRANCH PC/IR strobes look at inputs.
module riscv_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_ALU_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_illegal;
    logic       w_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                // PC+4 goes straight into the PC on the cycle the fetch lands.
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b10;
                unique case (bus.opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BR:        w_next = S_BRANCH;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_next      = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                // Target was precomputed into ALUOut during DECODE.
                w_alu_src_a = 2'b01;
                w_alu_op    = 2'b01;
                w_pc_src    = 1'b1;
                w_pc_write  = bus.zero;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: w_illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 1'b1;
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.iord       = w_iord;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.reg_write  = w_reg_write;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.illegal    = w_illegal;
    assign bus.instret    = r_instret;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: per-cycle output signatures
// checked against hand-written constants.
module tb_riscv_multicycle_ctrl;
    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {mem_req,mem_we,iord,ir_write,pc_write,pc_src,a[1:0],b[1:0],op[1:0],reg_write,mem_to_reg,illegal}
    localparam logic [14:0] E_ZERO  = 15'b000000_00_00_00_000;
    localparam logic [14:0] E_FETR  = 15'b100110_00_01_00_000;
    localparam logic [14:0] E_FETW  = 15'b100000_00_01_00_000;
    localparam logic [14:0] E_DEC   = 15'b000000_10_10_00_000;
    localparam logic [14:0] E_MADDR = 15'b000000_01_10_00_000;
    localparam logic [14:0] E_MRD   = 15'b101000_00_00_00_000;
    localparam logic [14:0] E_MWB   = 15'b000000_00_00_00_110;
    localparam logic [14:0] E_MWR   = 15'b111000_00_00_00_000;
    localparam logic [14:0] E_EXR   = 15'b000000_01_00_10_000;
    localparam logic [14:0] E_AWB   = 15'b000000_00_00_00_100;
    localparam logic [14:0] E_BRT   = 15'b000011_01_00_01_000;
    localparam logic [14:0] E_BRN   = 15'b000001_01_00_01_000;
    localparam logic [14:0] E_TRAP  = 15'b000000_00_00_00_001;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    riscv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    riscv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] outs;
    assign outs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                   bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.reg_write, bus.mem_to_reg, bus.illegal};

    task automatic chk(input string tag, input logic [14:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s outs got=%b exp=%b", tag, outs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        checks++;
        assert (bus.instret === exp) else begin
            errors++;
            $error("FAIL %s instret got=%0d exp=%0d", tag, bus.instret, exp);
        end
    endtask

    // Advance one cycle, drive this cycle's inputs, then let outputs settle.
    task automatic go(input logic rdy, input logic z, input logic [6:0] op);
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op;
        #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 7'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outs", E_ZERO);
        chk_cnt("reset_cnt", 0);

        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_idle", E_ZERO);
        go(1, 0, OP_R);   chk("rel_fetch", E_FETR); chk_cnt("rel_cnt", 0);

        // R-type, zero wait
        go(1, 0, OP_R);   chk("r_decode", E_DEC);
        go(1, 0, OP_R);   chk("r_exec", E_EXR);
        go(1, 0, OP_R);   chk("r_wb", E_AWB); chk_cnt("r_cnt_pre", 0);

        // lw with three wait cycles in MEM_READ
        go(1, 0, OP_LW);  chk("lw_fetch", E_FETR); chk_cnt("r_cnt_post", 1);
        go(1, 0, OP_LW);  chk("lw_decode", E_DEC);
        go(1, 0, OP_LW);  chk("lw_addr", E_MADDR);
        for (int i = 0; i < 3; i++) begin
            go(0, 0, OP_LW); chk("lw_wait", E_MRD);
        end
        go(1, 0, OP_LW);  chk("lw_read", E_MRD);
        go(1, 0, OP_LW);  chk("lw_wb", E_MWB);

        // beq taken, then not taken
        go(1, 0, OP_BR);  chk("bq1_fetch", E_FETR); chk_cnt("lw_cnt", 2);
        go(1, 0, OP_BR);  chk("bq1_decode", E_DEC);
        go(1, 1, OP_BR);  chk("bq1_taken", E_BRT);
        go(1, 0, OP_BR);  chk("bq2_fetch", E_FETR); chk_cnt("bq1_cnt", 3);
        go(1, 0, OP_BR);  chk("bq2_decode", E_DEC);
        go(1, 0, OP_BR);  chk("bq2_nt", E_BRN);

        // sw zero wait, with one stalled fetch first
        go(0, 0, OP_SW);  chk("sw_fetch_wait", E_FETW); chk_cnt("bq2_cnt", 4);
        go(1, 0, OP_SW);  chk("sw_fetch", E_FETR);
        go(1, 0, OP_SW);  chk("sw_decode", E_DEC);
        go(1, 0, OP_SW);  chk("sw_addr", E_MADDR);
        go(1, 0, OP_SW);  chk("sw_write", E_MWR); chk_cnt("sw_cnt_pre", 4);

        // illegal opcode traps and sticks
        go(1, 0, OP_BAD); chk("ill_fetch", E_FETR); chk_cnt("sw_cnt", 5);
        go(1, 0, OP_BAD); chk("ill_decode", E_DEC);
        for (int i = 0; i < 20; i++) begin
            go(i[0], i[1], OP_R); chk("trap_hold", E_TRAP);
        end
        chk_cnt("trap_cnt", 5);
        rst = 1'b1;
        #1 chk("trap_rst", E_ZERO);
        chk_cnt("trap_rst_cnt", 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("trap_rel_idle", E_ZERO);

        // reset pulsed while a store waits on memory
        go(1, 0, OP_SW);  chk("sw2_fetch", E_FETR);
        go(1, 0, OP_SW);  chk("sw2_decode", E_DEC);
        go(1, 0, OP_SW);  chk("sw2_addr", E_MADDR);
        go(0, 0, OP_SW);  chk("sw2_wait0", E_MWR);
        go(0, 0, OP_SW);  chk("sw2_wait1", E_MWR); chk_cnt("sw2_cnt_pre", 0);
        #2 rst = 1'b1;
        #1 chk("sw2_rst_outs", E_ZERO);
        chk_cnt("sw2_rst_cnt", 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1 chk("sw2_rel_idle", E_ZERO);
        go(1, 0, OP_R);   chk("sw2_rel_fetch", E_FETR); chk_cnt("sw2_rel_cnt", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
